timestamp_reader: RTL and testbench
===================================

# timestamp_reader

Consumer side of the 24-bit mission timestamp. Samples the free-running TIMESTAMP bus from the 10 Hz counter domain into the system clock domain, and on each event request freezes a coherent copy. It then streams that copy as three bytes (MSB first) over a valid/ready byte interface to the telemetry packet builder. It also flags requests dropped while a transfer is in flight.

## Interface
Parameters:
- none; widths are fixed: 24-bit timestamp, 8-bit byte stream, 8-bit request counter.

Ports:
- CLK  input  1  system clock; the only clock in this block.
- RESET  input  1  synchronous, active-high reset.
- TIMESTAMP  input  24  timestamp from the 10 Hz counter domain; asynchronous to CLK; changes at most once per 100 ms.
- STAMP_REQ  input  1  single-cycle request to capture and send the current timestamp.
- OVR_CLR  input  1  clears OVERRUN.
- DATA_OUT  output  8  current byte.
- DATA_VALID  output  1  DATA_OUT holds a valid byte.
- DATA_READY  input  1  downstream accepts the byte when DATA_VALID and DATA_READY are both high on a CLK edge.
- BUSY  output  1  high while a 3-byte transfer is in progress.
- OVERRUN  output  1  sticky: a STAMP_REQ was dropped.
- REQ_COUNT  output  8  number of accepted requests; wraps 255 -> 0.

## Operation
- Reset values: DATA_OUT=0, DATA_VALID=0, BUSY=0, OVERRUN=0, REQ_COUNT=0, and all internal registers = 0. The state machine resets to IDLE.
- Synchroniser:
  - TIMESTAMP is registered into ts_s1 and then ts_s2 on every CLK edge.
  - ts_stable <= ts_s2 only when ts_s1 == ts_s2. Otherwise ts_stable holds.
  - Multi-bit skew during a counter transition therefore never reaches ts_stable.
- FSM states: IDLE, SEND_HI, SEND_MID, SEND_LO.
  - IDLE: on STAMP_REQ, shadow <= ts_stable, REQ_COUNT += 1, go to SEND_HI.
  - SEND_HI: DATA_OUT = shadow[23:16] and DATA_VALID = 1. On handshake, go to SEND_MID.
  - SEND_MID: DATA_OUT = shadow[15:8]. On handshake, go to SEND_LO.
  - SEND_LO: DATA_OUT = shadow[7:0]. On handshake, go to IDLE.
- While DATA_VALID is high, DATA_OUT is stable until the handshake. DATA_VALID never drops without a handshake.
- BUSY = 1 in every state except IDLE.
- The shadow register is frozen for the whole transfer; TIMESTAMP changes mid-transfer do not affect the bytes sent.
- STAMP_REQ outside IDLE:
  - The request is dropped and OVERRUN <= 1.
  - REQ_COUNT is unchanged.
  - This includes the cycle of the final SEND_LO handshake.
- OVR_CLR clears OVERRUN. If OVR_CLR and a dropped request occur in the same cycle, set wins (OVERRUN = 1).
- RESET asserted mid-transfer aborts the transfer: DATA_VALID = 0 on the next edge and no partial bytes are resumed. OVERRUN and REQ_COUNT are cleared.
- In IDLE, DATA_OUT holds its last driven value; consumers ignore it while DATA_VALID = 0.

## Timing
- Capture latency: a TIMESTAMP change that is stable before edge k appears in ts_stable after edge k+2.
- A STAMP_REQ sampled at edge n latches ts_stable as it stands before edge n.
- With DATA_READY held high:
  - Bytes transfer at edges n+1, n+2 and n+3.
  - DATA_VALID is high from edge n through edge n+3.
  - Back in IDLE after edge n+3; the next request is accepted at edge n+4 or later.
- DATA_READY low stalls the current state indefinitely. There is no timeout.
- Throughput: at most one request every 4 CLK cycles.
- CLK must be at least 1 kHz. In practice it is many orders of magnitude faster than 10 Hz, so the stability filter always settles between counter ticks.

## Structure
- Shared package holds:
  - TS_WIDTH = 24 and BYTE_WIDTH = 8.
  - The FSM state encoding (2-bit localparams IDLE, SEND_HI, SEND_MID, SEND_LO), reused by the packet builder's monitor.
- One natural sub-module: ts_bus_sync, containing the two-stage register plus the equality filter (TIMESTAMP in, ts_stable out). The FSM, shadow register, counter and flags stay in timestamp_reader.

## Test plan
- Reset: assert RESET for 2 cycles mid-transfer (state SEND_MID) -> next cycle DATA_VALID=0, BUSY=0, OVERRUN=0, REQ_COUNT=0. A fresh request then sends all three bytes.
- Basic read: TIMESTAMP=24'hA5C3F1 held for 10 cycles, pulse STAMP_REQ, DATA_READY=1 -> bytes A5, C3, F1 on three consecutive cycles. BUSY high for exactly 3 cycles. REQ_COUNT=1.
- Backpressure and freeze:
  - TIMESTAMP=24'h000010, request, then DATA_READY=0 for 5 cycles in SEND_MID.
  - Meanwhile change TIMESTAMP to 24'h000011.
  - Required: DATA_OUT holds 00 while stalled; the byte sequence is 00, 00, 10.
- Skewed transition: drive TIMESTAMP 24'h00FFFF -> 24'h010000 with the upper byte changing one cycle before the lower bytes -> ts_stable only ever takes 00FFFF or 010000, never 01FFFF.
- Overrun:
  - Request, then a second STAMP_REQ during SEND_HI and a third on the SEND_LO handshake cycle -> OVERRUN=1, REQ_COUNT=1.
  - OVR_CLR pulse -> OVERRUN=0.
  - OVR_CLR coincident with a dropped request -> OVERRUN stays 1.
- Counter wrap: 256 accepted requests -> REQ_COUNT returns to 0, with no OVERRUN set.

Source files
------------

// File: rtl/timestamp_reader_pkg.sv
// rtl/timestamp_reader_pkg.sv - shared widths and FSM encoding for the timestamp reader
package timestamp_reader_pkg;

   localparam int TS_WIDTH   = 24;
   localparam int BYTE_WIDTH = 8;

   // State encoding, also decoded by the packet builder's monitor
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SEND_HI  = 2'd1;
   localparam logic [1:0] SEND_MID = 2'd2;
   localparam logic [1:0] SEND_LO  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE     = IDLE,
      S_SEND_HI  = SEND_HI,
      S_SEND_MID = SEND_MID,
      S_SEND_LO  = SEND_LO
   } state_e;

endpackage

// File: rtl/timestamp_reader_ts_bus_sync.sv
// rtl/timestamp_reader_ts_bus_sync.sv - two-stage sampler with equality filter for the slow timestamp bus
import timestamp_reader_pkg::*;

module ts_bus_sync (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [TS_WIDTH-1:0] TIMESTAMP,
   output logic [TS_WIDTH-1:0] ts_stable
);

   logic [TS_WIDTH-1:0] ts_s1;
   logic [TS_WIDTH-1:0] ts_s2;

   // Two back-to-back samples must agree before the value is trusted, so a
   // bus caught mid-transition (bits skewed) is never forwarded.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ts_s1     <= '0;
         ts_s2     <= '0;
         ts_stable <= '0;
      end else begin
         ts_s1 <= TIMESTAMP;
         ts_s2 <= ts_s1;
         if (ts_s1 == ts_s2)
            ts_stable <= ts_s2;
      end
   end

endmodule

// File: rtl/timestamp_reader.sv
// rtl/timestamp_reader.sv - freezes a coherent timestamp on request and streams it as three bytes
import timestamp_reader_pkg::*;

module timestamp_reader (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [TS_WIDTH-1:0]   TIMESTAMP,
   input  logic                  STAMP_REQ,
   input  logic                  OVR_CLR,
   output logic [BYTE_WIDTH-1:0] DATA_OUT,
   output logic                  DATA_VALID,
   input  logic                  DATA_READY,
   output logic                  BUSY,
   output logic                  OVERRUN,
   output logic [7:0]            REQ_COUNT
);

   state_e              state;
   logic [TS_WIDTH-1:0] shadow;
   logic [TS_WIDTH-1:0] ts_stable;
   logic                handshake;

   ts_bus_sync u_sync (
      .CLK       (CLK),
      .RESET     (RESET),
      .TIMESTAMP (TIMESTAMP),
      .ts_stable (ts_stable)
   );

   assign handshake = DATA_VALID && DATA_READY;

   // Transfer FSM: capture into shadow, then present MSB..LSB, advancing only on handshake
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= S_IDLE;
         shadow     <= '0;
         DATA_OUT   <= '0;
         DATA_VALID <= 1'b0;
         BUSY       <= 1'b0;
         REQ_COUNT  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (STAMP_REQ) begin
                  shadow     <= ts_stable;
                  DATA_OUT   <= ts_stable[23:16];
                  DATA_VALID <= 1'b1;
                  BUSY       <= 1'b1;
                  REQ_COUNT  <= REQ_COUNT + 8'd1;
                  state      <= S_SEND_HI;
               end
            end
            S_SEND_HI: begin
               if (handshake) begin
                  DATA_OUT <= shadow[15:8];
                  state    <= S_SEND_MID;
               end
            end
            S_SEND_MID: begin
               if (handshake) begin
                  DATA_OUT <= shadow[7:0];
                  state    <= S_SEND_LO;
               end
            end
            S_SEND_LO: begin
               // DATA_OUT keeps the last byte; it is ignored while DATA_VALID is low
               if (handshake) begin
                  DATA_VALID <= 1'b0;
                  BUSY       <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Sticky drop flag: any request seen outside IDLE sets it, and set beats clear
   always_ff @(posedge CLK) begin
      if (RESET)
         OVERRUN <= 1'b0;
      else if (STAMP_REQ && (state != S_IDLE))
         OVERRUN <= 1'b1;
      else if (OVR_CLR)
         OVERRUN <= 1'b0;
   end

endmodule

// File: tb/tb_timestamp_reader.sv
// tb/tb_timestamp_reader.sv - scoreboard bench for timestamp_reader
module tb_timestamp_reader;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [23:0] TIMESTAMP = '0;
   logic        STAMP_REQ = 1'b0;
   logic        OVR_CLR = 1'b0;
   logic [7:0]  DATA_OUT;
   logic        DATA_VALID;
   logic        DATA_READY = 1'b1;
   logic        BUSY;
   logic        OVERRUN;
   logic [7:0]  REQ_COUNT;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_cnt = '0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;

   timestamp_reader u_dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .TIMESTAMP  (TIMESTAMP),
      .STAMP_REQ  (STAMP_REQ),
      .OVR_CLR    (OVR_CLR),
      .DATA_OUT   (DATA_OUT),
      .DATA_VALID (DATA_VALID),
      .DATA_READY (DATA_READY),
      .BUSY       (BUSY),
      .OVERRUN    (OVERRUN),
      .REQ_COUNT  (REQ_COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic request(input logic [23:0] ts);
      STAMP_REQ = 1'b1;
      exp_q.push_back(ts[23:16]);
      exp_q.push_back(ts[15:8]);
      exp_q.push_back(ts[7:0]);
      exp_cnt = exp_cnt + 8'd1;
      tick();
      STAMP_REQ = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (BUSY === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("idle_timeout", {31'd0, BUSY}, 32'd0);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      exp_q.delete();
      exp_cnt = '0;
      RESET = 1'b0;
   endtask

   // Byte monitor: pops expected bytes on handshake, and checks hold while stalled
   always @(negedge CLK) begin
      if (RESET) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", {31'd0, DATA_VALID}, 32'd1);
            check("stall_data", {24'd0, DATA_OUT}, {24'd0, prev_data});
         end
         if (DATA_VALID && DATA_READY) begin
            if (exp_q.size() == 0)
               check("unexpected_byte", {24'd0, DATA_OUT}, 32'hFFFF_FFFF);
            else
               check("byte", {24'd0, DATA_OUT}, {24'd0, exp_q.pop_front()});
         end
         prev_stall = DATA_VALID && !DATA_READY;
         prev_data  = DATA_OUT;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles;
      logic [23:0] ts;
      logic skew_ok;

      // Power-up reset values
      tick();
      tick();
      check("rst_data", {24'd0, DATA_OUT}, 32'd0);
      check("rst_valid", {31'd0, DATA_VALID}, 32'd0);
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_ovr", {31'd0, OVERRUN}, 32'd0);
      check("rst_cnt", {24'd0, REQ_COUNT}, 32'd0);
      RESET = 1'b0;

      // Reset mid-transfer, parked in SEND_MID
      TIMESTAMP = 24'h123456;
      repeat (10) tick();
      DATA_READY = 1'b0;
      request(24'h123456);
      DATA_READY = 1'b1;
      tick();
      DATA_READY = 1'b0;
      STAMP_REQ = 1'b1;
      tick();
      STAMP_REQ = 1'b0;
      check("pre_rst_ovr", {31'd0, OVERRUN}, 32'd1);
      RESET = 1'b1;
      tick();
      check("mid_rst_valid", {31'd0, DATA_VALID}, 32'd0);
      check("mid_rst_busy", {31'd0, BUSY}, 32'd0);
      check("mid_rst_ovr", {31'd0, OVERRUN}, 32'd0);
      check("mid_rst_cnt", {24'd0, REQ_COUNT}, 32'd0);
      tick();
      exp_q.delete();
      exp_cnt = '0;
      RESET = 1'b0;
      DATA_READY = 1'b1;
      repeat (4) tick();
      request(24'h123456);
      wait_idle();
      check("post_rst_sb", exp_q.size(), 32'd0);

      // Basic read with BUSY width
      TIMESTAMP = 24'hA5C3F1;
      repeat (10) tick();
      request(24'hA5C3F1);
      busy_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         if (BUSY) busy_cycles++;
         tick();
      end
      check("busy_cycles", busy_cycles, 32'd3);
      check("basic_cnt", {24'd0, REQ_COUNT}, {24'd0, exp_cnt});
      check("basic_sb", exp_q.size(), 32'd0);

      // Backpressure in SEND_MID while the bus changes
      TIMESTAMP = 24'h000010;
      repeat (10) tick();
      request(24'h000010);
      tick();
      DATA_READY = 1'b0;
      TIMESTAMP = 24'h000011;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold", {24'd0, DATA_OUT}, 32'h00);
         tick();
      end
      DATA_READY = 1'b1;
      wait_idle();
      check("bp_sb", exp_q.size(), 32'd0);

      // Skewed transition: upper byte moves a cycle early
      TIMESTAMP = 24'h00FFFF;
      repeat (10) tick();
      TIMESTAMP = 24'h01FFFF;
      tick();
      TIMESTAMP = 24'h010000;
      skew_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (u_dut.u_sync.ts_stable != 24'h00FFFF && u_dut.u_sync.ts_stable != 24'h010000)
            skew_ok = 1'b0;
         tick();
      end
      check("skew_filter", {31'd0, skew_ok}, 32'd1);
      request(24'h010000);
      wait_idle();

      // Overrun: drop in SEND_HI and on the final handshake
      request(24'h010000);
      STAMP_REQ = 1'b1;
      tick();
      STAMP_REQ = 1'b0;
      tick();
      STAMP_REQ = 1'b1;
      tick();
      STAMP_REQ = 1'b0;
      check("ovr_set", {31'd0, OVERRUN}, 32'd1);
      check("ovr_cnt", {24'd0, REQ_COUNT}, {24'd0, exp_cnt});
      check("ovr_idle", {31'd0, BUSY}, 32'd0);
      OVR_CLR = 1'b1;
      tick();
      OVR_CLR = 1'b0;
      check("ovr_clr", {31'd0, OVERRUN}, 32'd0);
      request(24'h010000);
      STAMP_REQ = 1'b1;
      OVR_CLR = 1'b1;
      tick();
      STAMP_REQ = 1'b0;
      OVR_CLR = 1'b0;
      check("ovr_set_wins", {31'd0, OVERRUN}, 32'd1);
      wait_idle();
      check("ovr_cnt2", {24'd0, REQ_COUNT}, {24'd0, exp_cnt});

      // Counter wrap over 256 accepted requests with random stamps
      do_reset();
      for (int i = 0; i < 256; i++) begin
         ts = 24'($urandom);
         TIMESTAMP = ts;
         repeat (3) tick();
         request(ts);
         wait_idle();
         if (i == 254)
            check("cnt_255", {24'd0, REQ_COUNT}, 32'd255);
      end
      check("wrap_cnt", {24'd0, REQ_COUNT}, 32'd0);
      check("wrap_ovr", {31'd0, OVERRUN}, 32'd0);
      check("final_sb", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
